// File: rtl/data_mem_stall.sv
`default_nettype none
// ============================================================================
//  Module      : data_mem_stall
//  Description : Memory stage. Word-addressed data memory with a configurable
//                access latency, stall/done handshake to the pipeline, halt
//                drain, illegal-request detection and branch-condition
//                resolution for next-PC selection.
//                Optional compile-time feature: DATA_MEM_ALIGN_CHK_EN makes
//                odd byte addresses illegal (err pulse, no access).
//                MEM_LAT legal range is 1..7.
//  Revision    : 1.0 - initial release
// ============================================================================
module data_mem_stall #(
    parameter int DATA_W     = 16,
    parameter int DEPTH_LOG2 = 8,
    parameter int MEM_LAT    = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              halt,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [DATA_W-1:0] write_data,
    input  logic              branch,
    input  logic [1:0]        branch_cond,
    input  logic              zero,
    input  logic              neg,
    input  logic [DATA_W-1:0] branch_addr,
    input  logic [DATA_W-1:0] pc,
    output logic [DATA_W-1:0] branch_or_pc,
    output logic [DATA_W-1:0] read_data,
    output logic              stall,
    output logic              done,
    output logic              err,
    output logic              halted
);

    localparam logic [1:0] c_S_IDLE   = 2'd0;
    localparam logic [1:0] c_S_BUSY   = 2'd1;
    localparam logic [1:0] c_S_DONE   = 2'd2;
    localparam logic [1:0] c_S_HALTED = 2'd3;

    localparam int         c_DEPTH  = 1 << DEPTH_LOG2;
    localparam logic [2:0] c_LAT_M1 = 3'(MEM_LAT - 1);

    logic [1:0]            r_state;
    logic [2:0]            r_cnt;
    logic [DEPTH_LOG2-1:0] r_addr;
    logic [DATA_W-1:0]     r_wdata;
    logic                  r_is_wr;
    logic [DATA_W-1:0]     r_read_data;
    logic [DATA_W-1:0]     r_mem [c_DEPTH];

    logic                  w_req;
    logic                  w_misalign;
    logic                  w_illegal;
    logic                  w_accept;
    logic                  w_access;
    logic                  w_taken;
    logic [DEPTH_LOG2-1:0] w_index;
    logic                  w_unused_addr;

    // Byte address to word index; upper bits dropped so addresses wrap.
    assign w_index       = alu_result[DEPTH_LOG2:1];
    assign w_unused_addr = ^alu_result;

`ifdef DATA_MEM_ALIGN_CHK_EN
    assign w_misalign = alu_result[0];
`else
    assign w_misalign = 1'b0;
`endif

    assign w_req     = (mem_read | mem_write) & ~halt;
    assign w_illegal = (mem_read & mem_write) | w_misalign;
    assign w_accept  = (r_state == c_S_IDLE) & w_req & ~w_illegal;
    assign w_access  = (r_state == c_S_BUSY) & (r_cnt == 3'd0);

    // Handshake outputs; stall and err are forced low while reset is held.
    assign stall     = rst & (w_accept | (r_state == c_S_BUSY));
    assign err       = rst & (r_state == c_S_IDLE) & w_req & w_illegal;
    assign done      = (r_state == c_S_DONE);
    assign halted    = (r_state == c_S_HALTED);
    assign read_data = r_read_data;

    // Branch condition evaluation and next-PC mux, independent of the FSM.
    always_comb begin
        w_taken = 1'b0;
        case (branch_cond)
            2'b00:   w_taken = zero;
            2'b01:   w_taken = ~zero;
            2'b10:   w_taken = neg;
            2'b11:   w_taken = ~neg;
            default: w_taken = 1'b0;
        endcase
        w_taken      = w_taken & branch;
        branch_or_pc = w_taken ? branch_addr : pc;
    end

    // Access FSM: capture request, count down latency, complete, drain on halt.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= c_S_IDLE;
            r_cnt       <= 3'd0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_is_wr     <= 1'b0;
            r_read_data <= '0;
        end else begin
            case (r_state)
                c_S_IDLE: begin
                    if (halt) begin
                        r_state <= c_S_HALTED;
                    end else if (w_accept) begin
                        r_addr  <= w_index;
                        r_wdata <= write_data;
                        r_is_wr <= mem_write;
                        r_cnt   <= c_LAT_M1;
                        r_state <= c_S_BUSY;
                    end
                end
                c_S_BUSY: begin
                    if (r_cnt != 3'd0) begin
                        r_cnt <= r_cnt - 3'd1;
                    end else begin
                        if (!r_is_wr) begin
                            r_read_data <= r_mem[r_addr];
                        end
                        r_state <= c_S_DONE;
                    end
                end
                c_S_DONE: begin
                    r_state <= halt ? c_S_HALTED : c_S_IDLE;
                end
                default: begin
                    r_state <= c_S_HALTED;
                end
            endcase
        end
    end

    // Array write on the final BUSY cycle; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (w_access && r_is_wr) begin
            r_mem[r_addr] <= r_wdata;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_data_mem_stall.sv
`default_nettype none
// ============================================================================
//  Module      : tb_data_mem_stall
//  Description : Self-checking bench for data_mem_stall. Stimulus pushes
//                expected completions into a queue; a monitor pops and
//                compares whenever done or err is presented.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_data_mem_stall;

    localparam int LAT   = 2;
    localparam int K_RD  = 0;
    localparam int K_WR  = 1;
    localparam int K_ERR = 2;

    typedef struct {
        int          kind;
        logic [15:0] data;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        halt;
    logic        mem_read;
    logic        mem_write;
    logic [15:0] alu_result;
    logic [15:0] write_data;
    logic        branch;
    logic [1:0]  branch_cond;
    logic        zero;
    logic        neg;
    logic [15:0] branch_addr;
    logic [15:0] pc;
    logic [15:0] branch_or_pc;
    logic [15:0] read_data;
    logic        stall;
    logic        done;
    logic        err;
    logic        halted;

    int          checks = 0;
    int          errors = 0;
    int          cyc    = 0;
    exp_t        q[$];
    exp_t        mon_e;
    logic [15:0] model [256];

    data_mem_stall #(.DATA_W(16), .DEPTH_LOG2(8), .MEM_LAT(LAT)) dut (
        .clk          (clk),
        .rst          (rst),
        .halt         (halt),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .alu_result   (alu_result),
        .write_data   (write_data),
        .branch       (branch),
        .branch_cond  (branch_cond),
        .zero         (zero),
        .neg          (neg),
        .branch_addr  (branch_addr),
        .pc           (pc),
        .branch_or_pc (branch_or_pc),
        .read_data    (read_data),
        .stall        (stall),
        .done         (done),
        .err          (err),
        .halted       (halted)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every done/err pulse must match the oldest expected completion.
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            if (done === 1'b1) begin
                if (q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_done actual=done required=none (cycle %0d)", cyc);
                end else begin
                    mon_e = q.pop_front();
                    chk("done_cycle", cyc, mon_e.cyc);
                    if (mon_e.kind == K_ERR) begin
                        checks++; errors++;
                        $display("FAIL done_vs_err actual=done required=err (cycle %0d)", cyc);
                    end else if (mon_e.kind == K_RD) begin
                        chk("read_data", read_data, mon_e.data);
                    end
                end
            end
            if (err === 1'b1) begin
                if (q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_err actual=err required=none (cycle %0d)", cyc);
                end else begin
                    mon_e = q.pop_front();
                    chk("err_cycle", cyc, mon_e.cyc);
                    if (mon_e.kind != K_ERR) begin
                        checks++; errors++;
                        $display("FAIL err_vs_done actual=err required=done (cycle %0d)", cyc);
                    end
                end
            end
        end
    end

    task automatic idle_inputs();
        mem_read  = 1'b0;
        mem_write = 1'b0;
    endtask

    // One access: model predicts outcome, pushes it, holds inputs until done.
    task automatic do_access(input logic rd, input logic wr,
                             input logic [15:0] addr, input logic [15:0] wdata);
        exp_t e;
        int   idx;
        int   n;
        bit   bad;
        idx = (int'(addr) % 512) / 2;
        bad = rd && wr;
`ifdef DATA_MEM_ALIGN_CHK_EN
        if (addr[0]) bad = 1'b1;
`endif
        @(posedge clk); #1;
        mem_read   = rd;
        mem_write  = wr;
        alu_result = addr;
        write_data = wdata;
        if (bad) begin
            e.kind = K_ERR; e.data = 16'h0; e.cyc = cyc;
            q.push_back(e);
            @(negedge clk);
            chk("err_no_stall", stall, 0);
            @(posedge clk); #1;
            idle_inputs();
        end else begin
            e.kind = rd ? K_RD : K_WR;
            e.data = rd ? model[idx] : wdata;
            e.cyc  = cyc + LAT + 1;
            q.push_back(e);
            if (wr) model[idx] = wdata;
            for (n = 0; n < 20; n++) begin
                @(negedge clk);
                if (done === 1'b1) break;
                chk("stall_busy", stall, 1);
            end
            if (n == 20) begin
                checks++; errors++;
                $display("FAIL done_timeout actual=no_done required=done (cycle %0d)", cyc);
            end else begin
                chk("stall_at_done", stall, 0);
            end
            @(posedge clk); #1;
            idle_inputs();
        end
    endtask

    task automatic chk_branch(input logic b, input logic [1:0] c, input logic z,
                              input logic n, input logic [15:0] ba, input logic [15:0] p);
        logic tk;
        branch = b; branch_cond = c; zero = z; neg = n; branch_addr = ba; pc = p;
        #1;
        case (c)
            2'b00:   tk = z;
            2'b01:   tk = !z;
            2'b10:   tk = n;
            default: tk = !n;
        endcase
        chk("branch_or_pc", branch_or_pc, (b && tk) ? ba : p);
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int          t0;
        int          r;
        int          idx;
        logic [15:0] a;

        rst = 1'b0; halt = 1'b0;
        mem_read = 1'b0; mem_write = 1'b0;
        alu_result = 16'h0; write_data = 16'h0;
        branch = 1'b0; branch_cond = 2'b00; zero = 1'b0; neg = 1'b0;
        branch_addr = 16'h0; pc = 16'h0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_read_data", read_data, 0);
        chk("rst_stall", stall, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_halted", halted, 0);
        @(posedge clk); #1;
        rst = 1'b1;

        // Branch selection: directed lt cases, then random.
        chk_branch(1'b1, 2'b10, 1'b0, 1'b1, 16'h0040, 16'h0022);
        chk_branch(1'b1, 2'b10, 1'b0, 1'b0, 16'h0040, 16'h0022);
        for (int i = 0; i < 24; i++) begin
            chk_branch(1'($urandom), 2'($urandom), 1'($urandom), 1'($urandom),
                       16'($urandom), 16'($urandom));
        end

        // Prefill the word range used below so every read has a known value.
        for (int i = 0; i < 32; i++) begin
            do_access(1'b0, 1'b1, 16'(i * 2), 16'($urandom));
        end

        // Basic write then read, with stall/done timing.
        do_access(1'b0, 1'b1, 16'h0010, 16'hBEEF);
        do_access(1'b1, 1'b0, 16'h0010, 16'h0000);

        // Address wrap.
        do_access(1'b0, 1'b1, 16'h0010, 16'h1234);
        do_access(1'b1, 1'b0, 16'h0210, 16'h0000);

        // Simultaneous read and write is rejected, word untouched.
        do_access(1'b0, 1'b1, 16'h0020, 16'h5555);
        do_access(1'b1, 1'b1, 16'h0020, 16'hFFFF);
        do_access(1'b1, 1'b0, 16'h0020, 16'h0000);

        // Odd address: rejected with the alignment check, else truncated.
        do_access(1'b0, 1'b1, 16'h0011, 16'h5A5A);
        do_access(1'b1, 1'b0, 16'h0010, 16'h0000);

        // Random traffic over the prefilled words.
        for (int i = 0; i < 120; i++) begin
            r   = $urandom_range(0, 9);
            idx = $urandom_range(0, 31);
            a   = 16'(($urandom & 32'hFE00) | (idx << 1) | $urandom_range(0, 1));
            if (r == 0)      do_access(1'b1, 1'b1, a, 16'($urandom));
            else if (r < 5)  do_access(1'b0, 1'b1, a, 16'($urandom));
            else             do_access(1'b1, 1'b0, a, 16'h0000);
        end

        // Halt during a write: access completes, then HALTED, requests ignored.
        @(posedge clk); #1;
        mem_write = 1'b1; alu_result = 16'h0004; write_data = 16'h00AA;
        t0 = cyc;
        begin
            exp_t e;
            e.kind = K_WR; e.data = 16'h00AA; e.cyc = t0 + LAT + 1;
            q.push_back(e);
        end
        model[2] = 16'h00AA;
        @(posedge clk); #1;
        halt = 1'b1;
        @(negedge clk);
        chk("halt_busy_stall", stall, 1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        mem_write = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("halted_set", halted, 1);
        halt = 1'b0;
        mem_read = 1'b1; alu_result = 16'h0004;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("halted_no_stall", stall, 0);
            chk("halted_hold", halted, 1);
        end
        @(posedge clk); #1;
        mem_read = 1'b0;
        rst = 1'b0;
        #2;
        chk("halted_cleared", halted, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        do_access(1'b1, 1'b0, 16'h0004, 16'h0000);

        // Reset in the middle of a write: outputs clear at once, no write.
        do_access(1'b0, 1'b1, 16'h0030, 16'hC3C3);
        do_access(1'b1, 1'b0, 16'h0030, 16'h0000);
        @(posedge clk); #1;
        mem_write = 1'b1; alu_result = 16'h0030; write_data = 16'h7777;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("midrst_read_data", read_data, 0);
        chk("midrst_stall", stall, 0);
        chk("midrst_done", done, 0);
        mem_write = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        do_access(1'b1, 1'b0, 16'h0030, 16'h0000);

        repeat (4) @(posedge clk);
        chk("queue_drained", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/data_mem_stall.md
Name: data_mem_stall

Overview:
- Parametrised next-generation memory-stage block: word-addressed data memory with configurable access latency, a stall/done handshake to the pipeline, and branch-condition resolution selecting branch target vs PC.
- Sits between execute and writeback.
- Replaces the single-cycle data memory plus branch mux.
- Adds multi-cycle access, branch conditions, halt-drain and alignment checking.

Parameters:
- DATA_W, 16, data and address width in bits.
- DEPTH_LOG2, 8, log2 of number of words in the internal array (256 words).
- MEM_LAT, 2, access latency in cycles; legal range 1..7.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- halt  in  1  processor halt; stops acceptance of new accesses.
- mem_read  in  1  load request (level, from control).
- mem_write  in  1  store request (level, from control).
- alu_result  in  DATA_W  byte address.
- write_data  in  DATA_W  store data.
- branch  in  1  instruction is a conditional branch.
- branch_cond  in  2  00 eq, 01 ne, 10 lt, 11 ge.
- zero  in  1  ALU result zero flag.
- neg  in  1  ALU result negative flag.
- branch_addr  in  DATA_W  branch target.
- pc  in  DATA_W  sequential next PC.
- branch_or_pc  out  DATA_W  selected next PC.
- read_data  out  DATA_W  registered load data.
- stall  out  1  pipeline must hold all inputs stable.
- done  out  1  one-cycle pulse when an access completes.
- err  out  1  one-cycle pulse on an illegal request.
- halted  out  1  block has drained and is halted.

Behaviour:
- Reset (rst=0, asynchronous):
  - state IDLE; read_data=0, done=0, err=0, halted=0, counter=0.
  - Array contents are not reset.
  - Reset mid-access abandons the access; no write occurs.
- Branch selection (combinational, independent of the FSM):
  - taken = branch & (eq:zero | ne:~zero | lt:neg | ge:~neg).
  - branch_or_pc = taken ? branch_addr : pc.
- Word index = alu_result[DEPTH_LOG2:1]. Higher address bits are ignored, so addresses wrap modulo 2^(DEPTH_LOG2+1) bytes.
- req = (mem_read | mem_write) & ~halt.
- stall = (state==IDLE & req & legal) | (state==BUSY). stall is 0 in DONE, HALTED and when err fires.
- FSM:
  - IDLE:
    - if halt, go to HALTED.
    - else if req & legal: capture address, data and rd/wr; counter=MEM_LAT-1; go to BUSY.
    - else if req & illegal: err=1 for one cycle, stay in IDLE, no access.
  - BUSY:
    - if counter!=0, decrement.
    - if counter==0, perform the access: a write updates the array, a read loads read_data. Go to DONE.
    - Captured values are used, so input changes during BUSY are ignored.
  - DONE: done=1, stall=0. Requests are not accepted this cycle. Next state is HALTED if halt, else IDLE.
  - HALTED: halted=1; all requests ignored, no stall, no err. Leaves only via reset.
- Latency:
  - Request seen in IDLE at cycle 0; BUSY for MEM_LAT cycles; done=1 at cycle MEM_LAT+1.
  - Next request is accepted no earlier than cycle MEM_LAT+2.
- read_data holds its value until the next read completes; writes do not change it.
- Illegal conditions:
  - mem_read & mem_write both set.
  - Misaligned address, when the optional feature below is enabled.
- halt asserted during BUSY: the access completes normally, then DONE, then HALTED.

Optional Feature:
- Macro: DATA_MEM_ALIGN_CHK_EN.
- Defined:
  - alu_result[0]=1 with a request is illegal.
  - err pulses for one cycle, no access occurs, no stall.
- Undefined:
  - alu_result[0] is ignored, so the access goes to the word at the truncated index.
  - err fires only for simultaneous read and write.

Test Plan:
- MEM_LAT=2. Write 0xBEEF to addr 0x0010 at cycle 0 → stall=1 in cycles 0–2; done=1 at cycle 3. Then read 0x0010 → read_data=0xBEEF with done at cycle 3 of the read.
- Read addr 0x0210 after writing 0x1234 to 0x0010 (DEPTH_LOG2=8) → read_data=0x1234 (wrap).
- mem_read=mem_write=1, addr 0x0020 → err=1 for one cycle, stall=0, the word at 0x0020 is unchanged on readback.
- With DATA_MEM_ALIGN_CHK_EN, write to 0x0011 → err pulse, no write. Without the macro, the same write lands at word 0x0010.
- halt asserted at cycle 1 of a write of 0x00AA to 0x0004 → write completes, done at cycle 3, halted=1 from cycle 4, later requests ignored.
- Branch checks: branch=1, cond=10, neg=1, branch_addr=0x0040, pc=0x0022 → branch_or_pc=0x0040. The same with neg=0 → 0x0022.
- Reset: rst low mid-BUSY → read_data=0, stall=0 immediately.
